conv3x3_window_mac: RTL and testbench

//  Consumes the three row taps and the window-valid flag from the 3-row line buffer. Builds a
//  3x3 sliding window and computes a pipelined 3x3 multiply-accumulate against 9 programmable

---
 rtl/conv_pkg.sv | 30 +++
 rtl/conv3x3_window_mac_mac3_row.sv | 48 ++++
 rtl/conv3x3_window_mac.sv | 179 +++++++++++++++++
 tb/tb_conv3x3_window_mac.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, tap indices and saturation helper
// for the 3x3 window multiply-accumulate.
package conv_pkg;

  localparam int NUM_TAPS    = 9;
  localparam int WT_IDX_BIAS = 9;

  function automatic int prod_w(input int dw, input int ww);
    return dw + ww + 1;
  endfunction

  function automatic int acc_w(input int dw, input int ww);
    return dw + ww + 5;
  endfunction

  // Clamp a signed value to the range of an ow-bit signed number.
  function automatic logic signed [63:0] sat(
    input logic signed [63:0] x,
    input int                 ow
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/conv3x3_window_mac_mac3_row.sv
// mac3_row: one window row, three pixels times three weights.
// S1 registers the products, S2 registers their sum.
module mac3_row
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_W-1:0]            px0_i,
  input  logic [DATA_W-1:0]            px1_i,
  input  logic [DATA_W-1:0]            px2_i,
  input  logic signed [WT_W-1:0]       wt0_i,
  input  logic signed [WT_W-1:0]       wt1_i,
  input  logic signed [WT_W-1:0]       wt2_i,
  output logic signed [DATA_W+WT_W+2:0] sum_o
);

  localparam int PW = prod_w(DATA_W, WT_W);
  localparam int SW = PW + 2;

  logic signed [PW-1:0] p_d [3];
  logic signed [PW-1:0] p_q [3];
  logic signed [SW-1:0] sum_d;

  // Pixels are zero-extended so the signed multiply sees them as unsigned.
  always_comb begin
    p_d[0] = PW'($signed({1'b0, px0_i})) * PW'(wt0_i);
    p_d[1] = PW'($signed({1'b0, px1_i})) * PW'(wt1_i);
    p_d[2] = PW'($signed({1'b0, px2_i})) * PW'(wt2_i);
    sum_d  = SW'(p_q[0]) + SW'(p_q[1]) + SW'(p_q[2]);
  end

  // S1 product registers and S2 row-sum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q[0] <= '0;
      p_q[1] <= '0;
      p_q[2] <= '0;
      sum_o  <= '0;
    end else begin
      p_q   <= p_d;
      sum_o <= sum_d;
    end
  end

endmodule

// File: rtl/conv3x3_window_mac.sv
// conv3x3_window_mac: 3x3 sliding window, 4-stage MAC with bias,
// shift and saturation. Define RELU_EN to clamp negatives to zero.
module conv3x3_window_mac
  import conv_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int WT_W    = 8,
  parameter int COL_NUM = 128,
  parameter int ROW_NUM = 128,
  parameter int SHIFT   = 0,
  parameter int OUT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] row0,
  input  logic [DATA_W-1:0] row1,
  input  logic [DATA_W-1:0] row2,
  input  logic              wt_we,
  input  logic [3:0]        wt_addr,
  input  logic [WT_W-1:0]   wt_data,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              frame_done
);

  localparam int ACC_W = acc_w(DATA_W, WT_W);
  localparam int SW    = prod_w(DATA_W, WT_W) + 2;
  localparam int CW    = $clog2(COL_NUM);
  localparam int RW    = $clog2(ROW_NUM);

  localparam logic [CW-1:0] COL_LAST = CW'(COL_NUM - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW_NUM - 3);

  logic signed [WT_W-1:0]  wt_q [NUM_TAPS];
  logic signed [WT_W-1:0]  bias_q;
  logic [DATA_W-1:0]       win_q [3][3];
  logic [DATA_W-1:0]       win_d [3][3];
  logic [CW-1:0]           col_cnt_q;
  logic [CW-1:0]           col_cnt_d;
  logic [RW-1:0]           row_cnt_q;
  logic [RW-1:0]           row_cnt_d;
  logic                    v0;
  logic                    last0;
  logic                    v1_q, v2_q, v3_q;
  logic                    l1_q, l2_q, l3_q;
  logic signed [WT_W-1:0]  b1_q, b2_q;
  logic signed [SW-1:0]    rsum [3];
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc3_q;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [63:0]      sat_v;
  logic [OUT_W-1:0]        res;
  logic                    out_valid_q;
  logic                    frame_done_q;
  logic [OUT_W-1:0]        out_data_q;

  // Weight and bias register file; addresses past the bias are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) wt_q[k] <= '0;
      bias_q <= '0;
    end else if (wt_we) begin
      if (wt_addr == 4'(WT_IDX_BIAS)) bias_q <= wt_data;
      else if (int'(wt_addr) < NUM_TAPS) wt_q[wt_addr] <= wt_data;
    end
  end

  // Next window: shift each row left and append the incoming column.
  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = row0;
      win_d[1][2] = row1;
      win_d[2][2] = row2;
    end
  end

  // Column and window-row counters; a full window needs col >= 2.
  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (in_valid) begin
      if (col_cnt_q == COL_LAST) begin
        col_cnt_d = '0;
        row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end
    end
    v0    = in_valid && (col_cnt_q >= COL_WIN);
    last0 = v0 && (col_cnt_q == COL_LAST) && (row_cnt_q == ROW_LAST);
  end

  // Window and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
    end else begin
      win_q     <= win_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  // The products see the window including the column accepted this cycle.
  for (genvar r = 0; r < 3; r++) begin : g_row
    mac3_row #(
      .DATA_W (DATA_W),
      .WT_W   (WT_W)
    ) u_row (
      .clk   (clk),
      .rst_n (rst_n),
      .px0_i (win_d[r][0]),
      .px1_i (win_d[r][1]),
      .px2_i (win_d[r][2]),
      .wt0_i (wt_q[r*3]),
      .wt1_i (wt_q[r*3+1]),
      .wt2_i (wt_q[r*3+2]),
      .sum_o (rsum[r])
    );
  end

  // S3 total plus bias, S4 shift, saturate and optional clamp.
  always_comb begin
    acc_d  = ACC_W'(rsum[0]) + ACC_W'(rsum[1]) + ACC_W'(rsum[2])
           + ACC_W'(b2_q);
    acc_sh = acc3_q >>> SHIFT;
    sat_v  = sat(64'(acc_sh), OUT_W);
    res    = OUT_W'(sat_v);
`ifdef RELU_EN
    if (res[OUT_W-1]) res = '0;
`endif
  end

  // Valid, last flag and bias ride along with the data through S1..S4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      l1_q         <= 1'b0;
      l2_q         <= 1'b0;
      l3_q         <= 1'b0;
      b1_q         <= '0;
      b2_q         <= '0;
      acc3_q       <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      v1_q         <= v0;
      l1_q         <= last0;
      b1_q         <= bias_q;
      v2_q         <= v1_q;
      l2_q         <= l1_q;
      b2_q         <= b1_q;
      v3_q         <= v2_q;
      l3_q         <= l2_q;
      acc3_q       <= acc_d;
      out_valid_q  <= v3_q;
      frame_done_q <= v3_q && l3_q;
      if (v3_q) out_data_q <= res;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv3x3_window_mac.sv
// tb_conv3x3_window_mac: table vectors, hand sequences and random
// streams checked against a window-level reference model.
module tb_conv3x3_window_mac;

  localparam int COL  = 8;
  localparam int ROW  = 8;
  localparam int WROW = ROW - 2;
  localparam int NRES = (COL - 2) * (ROW - 2);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] row0 = '0, row1 = '0, row2 = '0;
  logic       wt_we = 1'b0;
  logic [3:0] wt_addr = '0;
  logic [7:0] wt_data = '0;
  logic       ov0, ov1, fd0, fd1;
  logic [7:0] od0, od1;

  always #5 clk = ~clk;

  conv3x3_window_mac #(
    .DATA_W(8), .WT_W(8), .COL_NUM(COL), .ROW_NUM(ROW),
    .SHIFT(0), .OUT_W(8)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .row0(row0), .row1(row1), .row2(row2),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .out_valid(ov0), .out_data(od0), .frame_done(fd0)
  );

  conv3x3_window_mac #(
    .DATA_W(8), .WT_W(8), .COL_NUM(COL), .ROW_NUM(ROW),
    .SHIFT(1), .OUT_W(8)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .row0(row0), .row1(row1), .row2(row2),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .out_valid(ov1), .out_data(od1), .frame_done(fd1)
  );

  typedef struct {
    int acc;
    bit last;
    int cyc;
  } exp_t;

  typedef struct {
    int pix;
    int w;
    int b;
    int e0;
    int e1;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t q[$];
  exp_t mon_e;
  int   got0[$];
  int   got1[$];
  int   nfd;
  int   wm[10];
  int   colbuf[3][COL];
  int   mcol, mrow;
  int   pix_mem[WROW][COL][3];
  vec_t tbl[5];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_out(input int acc, input int sh);
    int x;
    x = acc >>> sh;
    if (x > 127) x = 127;
    if (x < -128) x = -128;
`ifdef RELU_EN
    if (x < 0) x = 0;
`endif
    return x;
  endfunction

  function automatic void model_reset();
    q.delete();
    mcol = 0;
    mrow = 0;
    for (int k = 0; k < 10; k++) wm[k] = 0;
  endfunction

  // One clock of stimulus; the model sees weights as they were before
  // this cycle's write.
  task automatic step(input bit iv, input int p0, input int p1,
                      input int p2, input bit we, input int a,
                      input int d);
    int acc;
    logic signed [7:0] w8;
    in_valid = iv;
    row0 = 8'(p0);
    row1 = 8'(p1);
    row2 = 8'(p2);
    wt_we = we;
    wt_addr = 4'(a);
    wt_data = 8'(d);
    if (iv) begin
      colbuf[0][mcol] = p0;
      colbuf[1][mcol] = p1;
      colbuf[2][mcol] = p2;
      if (mcol >= 2) begin
        acc = wm[9];
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            acc += wm[r*3+c] * colbuf[r][mcol-2+c];
        q.push_back('{acc: acc,
                      last: (mcol == COL-1 && mrow == ROW-3),
                      cyc: cyc});
      end
      if (mcol == COL-1) begin
        mcol = 0;
        mrow = (mrow == ROW-3) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
    if (we && a <= 9) begin
      w8 = 8'(d);
      wm[a] = int'(w8);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wt_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    wt_we = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_valid", int'(ov0), 0);
    chk("rst_data", int'(od0), 0);
    chk("rst_fd", int'(fd0), 0);
    chk("rst_valid1", int'(ov1), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clr();
    got0.delete();
    got1.delete();
    nfd = 0;
  endtask

  task automatic drain();
    repeat (8) step(0, 0, 0, 0, 0, 0, 0);
    chk("pending", q.size(), 0);
  endtask

  task automatic rand_wts(input int m);
    for (int k = 0; k < 10; k++)
      step(0, 0, 0, 0, 1, k, int'($urandom_range(0, 2*m)) - m);
  endtask

  task automatic fill_pix(input int m);
    for (int r = 0; r < WROW; r++)
      for (int c = 0; c < COL; c++)
        for (int k = 0; k < 3; k++)
          pix_mem[r][c][k] = int'($urandom_range(0, m));
  endtask

  // mode 0 constant, 1 column index, 2 pix_mem; stop_at cuts the frame.
  task automatic frame(input int mode, input int cval, input bit gaps,
                       input int stop_at, input int wr_at,
                       input int wa, input int wd);
    int n;
    int p[3];
    n = 0;
    for (int r = 0; r < WROW; r++) begin
      for (int c = 0; c < COL; c++) begin
        if (n == stop_at) return;
        for (int k = 0; k < 3; k++)
          p[k] = (mode == 0) ? cval : (mode == 1) ? c : pix_mem[r][c][k];
        if (gaps && $urandom_range(0, 1) == 1)
          step(0, 0, 0, 0, 0, 0, 0);
        step(1, p[0], p[1], p[2], n == wr_at, wa, wd);
        n++;
      end
    end
  endtask

  // Scoreboard: every result must match the model, in order, 4 cycles on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov0) begin
        if (q.size() == 0) begin
          chk("unexpected_out", int'(ov0), 0);
        end else begin
          mon_e = q.pop_front();
          chk("out0", int'($signed(od0)), ref_out(mon_e.acc, 0));
          chk("out1_valid", int'(ov1), 1);
          chk("out1", int'($signed(od1)), ref_out(mon_e.acc, 1));
          chk("latency", cyc - mon_e.cyc, 4);
          chk("frame_done", int'(fd0), int'(mon_e.last));
          got0.push_back(int'($signed(od0)));
          got1.push_back(int'($signed(od1)));
          if (fd0) nfd++;
        end
      end else begin
        chk("idle_fd", int'(fd0), 0);
        chk("idle_valid1", int'(ov1), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{pix: 10,  w: 1,    b: 0,  e0: 90,  e1: 45};
    tbl[1] = '{pix: 255, w: 127,  b: 0,  e0: 127, e1: 127};
`ifdef RELU_EN
    tbl[2] = '{pix: 255, w: -128, b: 0,  e0: 0,   e1: 0};
    tbl[3] = '{pix: 7,   w: 0,    b: -1, e0: 0,   e1: 0};
    tbl[4] = '{pix: 3,   w: -2,   b: 5,  e0: 0,   e1: 0};
`else
    tbl[2] = '{pix: 255, w: -128, b: 0,  e0: -128, e1: -128};
    tbl[3] = '{pix: 7,   w: 0,    b: -1, e0: -1,   e1: -1};
    tbl[4] = '{pix: 3,   w: -2,   b: 5,  e0: -49,  e1: -25};
`endif

    do_reset();

    // Constant frames with uniform weights.
    foreach (tbl[i]) begin
      do_reset();
      for (int k = 0; k < 9; k++) step(0, 0, 0, 0, 1, k, tbl[i].w);
      step(0, 0, 0, 0, 1, 9, tbl[i].b);
      clr();
      frame(0, tbl[i].pix, 0, -1, -1, 0, 0);
      drain();
      chk("tbl_count", got0.size(), NRES);
      chk("tbl_fd", nfd, 1);
      foreach (got0[j]) chk("tbl_out0", got0[j], tbl[i].e0);
      foreach (got1[j]) chk("tbl_out1", got1[j], tbl[i].e1);
    end

    // Pixel = column index, only tap k2 set: outputs 2..7 per row.
    do_reset();
    step(0, 0, 0, 0, 1, 2, 1);
    clr();
    frame(1, 0, 0, -1, -1, 0, 0);
    drain();
    chk("col_count", got0.size(), NRES);
    foreach (got0[j]) chk("col_out", got0[j], 2 + (j % (COL - 2)));

    // Same random frame gapless then with bubbles; two frame_done pulses.
    do_reset();
    rand_wts(2);
    fill_pix(15);
    clr();
    frame(2, 0, 0, -1, -1, 0, 0);
    frame(2, 0, 1, -1, -1, 0, 0);
    drain();
    chk("gap_count", got0.size(), 2 * NRES);
    chk("gap_fd", nfd, 2);

    // Reset in the middle of a row, then a clean frame.
    do_reset();
    rand_wts(2);
    fill_pix(15);
    clr();
    frame(2, 0, 0, 3 * COL + 4, -1, 0, 0);
    do_reset();
    repeat (6) step(0, 0, 0, 0, 0, 0, 0);
    rand_wts(2);
    clr();
    frame(2, 0, 0, -1, -1, 0, 0);
    drain();
    chk("rst_count", got0.size(), NRES);
    chk("rst_fd", nfd, 1);

    // Weight writes while streaming, including one to an unused address.
    do_reset();
    rand_wts(1);
    fill_pix(20);
    clr();
    frame(2, 0, 0, -1, 20, 4, 2);
    frame(2, 0, 1, -1, 10, 12, 77);
    drain();
    chk("wr_count", got0.size(), 2 * NRES);
    chk("wr_fd", nfd, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
